con_ff_unit: RTL and testbench

//  Parametrised conditional-branch unit: evaluates the branch condition encoded in IR

---
 rtl/con_ff_if.sv | 27 ++
 rtl/con_ff_unit.sv | 89 ++++++++
 tb/tb_con_ff_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/con_ff_if.sv
// Bundle of the condition-unit control, operand and result signals.
// master drives the control/operand side; slave is the condition unit itself.
interface con_ff_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned COUNT_W = 16
);
  logic               con_a_in;
  logic               con_in;
  logic [31:0]        ir_in;
  logic [DATA_W-1:0]  bus_in;
  logic               con_out;
  logic               con_valid;
  logic               con_err;
  logic               a_held;
  logic [COUNT_W-1:0] taken_cnt;
  logic [COUNT_W-1:0] eval_cnt;

  modport master (
    output con_a_in, con_in, ir_in, bus_in,
    input  con_out, con_valid, con_err, a_held, taken_cnt, eval_cnt
  );

  modport slave (
    input  con_a_in, con_in, ir_in, bus_in,
    output con_out, con_valid, con_err, a_held, taken_cnt, eval_cnt
  );
endinterface

// File: rtl/con_ff_unit.sv
// Conditional-branch unit: evaluates the IR condition field against the bus (and an optional
// captured operand A), holds the result in the CON flip-flop and keeps saturating statistics.
module con_ff_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned C2_LSB  = 19,
  parameter int unsigned COUNT_W = 16
) (
  input logic        clk,
  input logic        clr,
  con_ff_if.slave    ff_io
);

  typedef enum logic [0:0] {StIdle, StAHeld} state_e;

  state_e             state_q;
  logic [DATA_W-1:0]  a_q;
  logic               con_q;
  logic               valid_q;
  logic               err_q;
  logic [COUNT_W-1:0] taken_q;
  logic [COUNT_W-1:0] eval_q;

  logic [2:0]        code;
  logic [DATA_W-1:0] x;
  logic              two_op;
  logic              x_zero;
  logic              x_neg;
  logic              result;

  assign code   = ff_io.ir_in[C2_LSB+2:C2_LSB];
  assign x      = ff_io.bus_in;
  assign two_op = code[2] & code[1];
  assign x_zero = (x == '0);
  assign x_neg  = x[DATA_W-1];

  always_comb begin
    result = 1'b0;
    unique case (code)
      3'b000:  result = x_zero;
      3'b001:  result = ~x_zero;
      3'b010:  result = ~x_neg;
      3'b011:  result = x_neg;
      3'b100:  result = ~x_neg & ~x_zero;
      3'b101:  result = x_neg | x_zero;
      3'b110:  result = (a_q == x);
      default: result = ($signed(a_q) < $signed(x));
    endcase
  end

  // con_in takes priority over con_a_in; a simultaneous capture is dropped.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      a_q     <= '0;
      con_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      taken_q <= '0;
      eval_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (ff_io.con_in) begin
        if (two_op && state_q == StIdle) begin
          err_q <= 1'b1;
          con_q <= 1'b0;
        end else begin
          con_q   <= result;
          valid_q <= 1'b1;
          if (eval_q != '1) eval_q <= eval_q + 1'b1;
          if (result && taken_q != '1) taken_q <= taken_q + 1'b1;
          // A is consumed by a two-operand test but the register keeps its value.
          if (two_op) state_q <= StIdle;
        end
      end else if (ff_io.con_a_in) begin
        a_q     <= x;
        state_q <= StAHeld;
      end
    end
  end

  assign ff_io.con_out   = con_q;
  assign ff_io.con_valid = valid_q;
  assign ff_io.con_err   = err_q;
  assign ff_io.a_held    = (state_q == StAHeld);
  assign ff_io.taken_cnt = taken_q;
  assign ff_io.eval_cnt  = eval_q;

endmodule

// File: tb/tb_con_ff_unit.sv
// Scoreboard bench for con_ff_unit: a 16-bit-counter build for function and a 4-bit build
// for counter saturation.
module tb_con_ff_unit;

  localparam int unsigned C2_LSB = 19;

  typedef struct {
    logic        err;
    logic        out;
    logic [15:0] taken;
    logic [15:0] evals;
    logic        held;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  con_ff_if #(.DATA_W(32), .COUNT_W(16)) i1 ();
  con_ff_if #(.DATA_W(32), .COUNT_W(4))  i2 ();

  con_ff_unit #(.DATA_W(32), .C2_LSB(C2_LSB), .COUNT_W(16)) dut1 (
    .clk   (clk),
    .clr   (clr),
    .ff_io (i1)
  );

  con_ff_unit #(.DATA_W(32), .C2_LSB(C2_LSB), .COUNT_W(4)) dut2 (
    .clk   (clk),
    .clr   (clr),
    .ff_io (i2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop one expectation per presented result (valid or err pulse).
  always @(negedge clk) begin
    if (!clr && (i1.con_valid || i1.con_err)) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1_err", 32'(i1.con_err), 32'(e.err));
        chk("dut1_valid", 32'(i1.con_valid), 32'(!e.err));
        chk("dut1_con_out", 32'(i1.con_out), 32'(e.out));
        chk("dut1_taken_cnt", 32'(i1.taken_cnt), 32'(e.taken));
        chk("dut1_eval_cnt", 32'(i1.eval_cnt), 32'(e.evals));
        chk("dut1_a_held", 32'(i1.a_held), 32'(e.held));
      end
    end
  end

  always @(negedge clk) begin
    if (!clr && (i2.con_valid || i2.con_err)) begin
      if (q2.size() == 0) begin
        chk("dut2_unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("dut2_con_out", 32'(i2.con_out), 32'(e.out));
        chk("dut2_taken_cnt", 32'(i2.taken_cnt), 32'(e.taken));
        chk("dut2_eval_cnt", 32'(i2.eval_cnt), 32'(e.evals));
      end
    end
  end

  task automatic push1(input logic err, input logic out, input int taken, input int evals,
                       input logic held);
    exp_t e;
    e.err = err; e.out = out; e.taken = 16'(taken); e.evals = 16'(evals); e.held = held;
    q1.push_back(e);
  endtask

  // One-cycle request on dut1; returns on the negedge after the active edge.
  task automatic op1(input logic a_in, input logic c_in, input logic [2:0] code,
                     input logic [31:0] bus);
    @(negedge clk);
    i1.con_a_in = a_in;
    i1.con_in   = c_in;
    i1.ir_in    = 32'(code) << C2_LSB;
    i1.bus_in   = bus;
    @(negedge clk);
    i1.con_a_in = 1'b0;
    i1.con_in   = 1'b0;
  endtask

  task automatic op2(input logic [2:0] code, input logic [31:0] bus);
    @(negedge clk);
    i2.con_in = 1'b1;
    i2.ir_in  = 32'(code) << C2_LSB;
    i2.bus_in = bus;
    @(negedge clk);
    i2.con_in = 1'b0;
  endtask

  initial begin
    i1.con_a_in = 0; i1.con_in = 0; i1.ir_in = 0; i1.bus_in = 0;
    i2.con_a_in = 0; i2.con_in = 0; i2.ir_in = 0; i2.bus_in = 0;
    repeat (2) @(negedge clk);
    chk("rst_con_out", 32'(i1.con_out), 0);
    chk("rst_con_valid", 32'(i1.con_valid), 0);
    chk("rst_con_err", 32'(i1.con_err), 0);
    chk("rst_a_held", 32'(i1.a_held), 0);
    chk("rst_taken_cnt", 32'(i1.taken_cnt), 0);
    chk("rst_eval_cnt", 32'(i1.eval_cnt), 0);
    clr = 1'b0;

    // T1..T3: single-operand codes
    push1(0, 1, 1, 1, 0); op1(0, 1, 3'b000, 32'h0000_0000);
    push1(0, 1, 2, 2, 0); op1(0, 1, 3'b001, 32'h8000_0000);
    push1(0, 1, 3, 3, 0); op1(0, 1, 3'b010, 32'h0000_0001);
    push1(0, 0, 3, 4, 0); op1(0, 1, 3'b011, 32'h0000_0001);
    push1(0, 0, 3, 5, 0); op1(0, 1, 3'b100, 32'h0000_0000);
    push1(0, 1, 4, 6, 0); op1(0, 1, 3'b101, 32'h0000_0000);
    push1(0, 0, 4, 7, 0); op1(0, 1, 3'b100, 32'hFFFF_FFFF);

    // T4: -2 < 3, then a two-operand code with no A held
    op1(1, 0, 3'b000, 32'hFFFF_FFFE);
    chk("t4_a_held_after_capture", 32'(i1.a_held), 1);
    push1(0, 1, 5, 8, 0); op1(0, 1, 3'b111, 32'h0000_0003);
    push1(1, 0, 5, 8, 0); op1(0, 1, 3'b110, 32'h0000_0003);

    // T5: simultaneous capture and compare; capture dropped, A consumed
    op1(1, 0, 3'b000, 32'd5);
    push1(0, 0, 5, 9, 0); op1(1, 1, 3'b110, 32'd7);

    // Single-operand test in A_HELD keeps A, then A==X hits
    op1(1, 0, 3'b000, 32'd10);
    push1(0, 1, 6, 10, 1); op1(0, 1, 3'b000, 32'd0);
    push1(0, 1, 7, 11, 0); op1(0, 1, 3'b110, 32'd10);

    // Signed boundary: max positive is not less than min negative
    op1(1, 0, 3'b000, 32'h7FFF_FFFF);
    push1(0, 0, 7, 12, 0); op1(0, 1, 3'b111, 32'h8000_0000);

    // clr in A_HELD acts without a clock edge
    op1(1, 0, 3'b000, 32'd1);
    chk("clr_pre_a_held", 32'(i1.a_held), 1);
    #2 clr = 1'b1;
    #1;
    chk("clr_async_a_held", 32'(i1.a_held), 0);
    chk("clr_async_con_out", 32'(i1.con_out), 0);
    chk("clr_async_taken", 32'(i1.taken_cnt), 0);
    chk("clr_async_eval", 32'(i1.eval_cnt), 0);
    @(negedge clk);
    clr = 1'b0;
    push1(1, 0, 0, 0, 0); op1(0, 1, 3'b110, 32'd0);

    // T6: 4-bit counters saturate at 15
    for (int i = 1; i <= 17; i++) begin
      exp_t e;
      e.err = 0; e.out = 1; e.held = 0;
      e.taken = 16'((i > 15) ? 15 : i);
      e.evals = 16'((i > 15) ? 15 : i);
      q2.push_back(e);
      op2(3'b000, 32'd0);
    end
    chk("t6_eval_sat", 32'(i2.eval_cnt), 15);

    repeat (3) @(negedge clk);
    chk("q1_drained", 32'(q1.size()), 0);
    chk("q2_drained", 32'(q2.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
